// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared state encoding and counter widths for TX-side schedulers
package tx_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_FLUSH, S_GAP} state_t;
  localparam int MAX_LEN_DEF = 1518;
  localparam int CNT_W = 11;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first request after ptr wins
module rr_pick #(
  parameter int N = 4,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = PW'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin frame-atomic mux of N_SRC egress FIFOs into the PHY TX FIFO
module tx_frame_arbiter
  import tx_sched_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   src_frame_rdy,
  input  logic [N_SRC-1:0]   src_empty,
  input  logic [8*N_SRC-1:0] src_dout,
  input  logic [N_SRC-1:0]   src_eod,
  output logic [N_SRC-1:0]   src_rden,
  input  logic               dst_full,
  output logic [7:0]         dst_din,
  output logic               dst_eod,
  output logic               dst_wren,
  output logic [2:0]         grant,
  output logic               busy,
  output logic               trunc_pulse
);
  localparam int GW = $clog2(N_SRC);
  state_t st;
  logic [2:0] rr_ptr, pidx;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0] gap_cnt;
  logic [GW-1:0] gi;
  logic pv, xfer, last, pop;
  rr_pick #(.N(N_SRC), .PW(3)) u_pick (.req(src_frame_rdy), .ptr(rr_ptr), .idx(pidx), .valid(pv));
  assign gi = grant[GW-1:0];
  assign last = byte_cnt == CNT_W'(MAX_LEN - 1);
  assign xfer = st == S_COPY && !src_empty[gi] && !dst_full;
  assign pop = xfer || (st == S_FLUSH && !src_empty[gi]);
  assign src_rden = pop ? N_SRC'(1) << gi : '0;
  assign dst_wren = xfer;
  assign dst_din = src_dout[8*gi +: 8];
  assign dst_eod = xfer && (src_eod[gi] || last);
  assign busy = st != S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE;
      rr_ptr <= 3'(N_SRC - 1);
      grant <= '0;
      byte_cnt <= '0;
      gap_cnt <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= 1'b0;
      case (st)
        S_IDLE: if (pv) begin
          grant <= pidx;
          st <= S_COPY;
        end
        S_COPY: if (xfer) begin
          if (src_eod[gi]) begin
            rr_ptr <= grant;
            byte_cnt <= '0;
            st <= GAP_CYC == 0 ? S_IDLE : S_GAP;
          end else if (last) begin
            trunc_pulse <= 1'b1;
            byte_cnt <= '0;
            st <= S_FLUSH;
          end else byte_cnt <= byte_cnt + 1'b1;
        end
        S_FLUSH: if (!src_empty[gi] && src_eod[gi]) begin
          rr_ptr <= grant;
          st <= GAP_CYC == 0 ? S_IDLE : S_GAP;
        end
        default: if (int'(gap_cnt) == GAP_CYC - 1) begin
          gap_cnt <= '0;
          st <= S_IDLE;
        end else gap_cnt <= gap_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized source/sink bench with a frame-level scoreboard model
module tb_tx_frame_arbiter;
  localparam int N = 4, ML = 1518, GAP = 2;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] src_frame_rdy, src_empty, src_eod, src_rden;
  logic [8*N-1:0] src_dout;
  logic dst_full, dst_eod, dst_wren, busy, trunc_pulse;
  logic [7:0] dst_din;
  logic [2:0] grant;
  tx_frame_arbiter #(.N_SRC(N), .MAX_LEN(ML), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .src_frame_rdy(src_frame_rdy), .src_empty(src_empty),
    .src_dout(src_dout), .src_eod(src_eod), .src_rden(src_rden), .dst_full(dst_full),
    .dst_din(dst_din), .dst_eod(dst_eod), .dst_wren(dst_wren), .grant(grant),
    .busy(busy), .trunc_pulse(trunc_pulse));
  int vec = 0, mis = 0;
  logic [8:0] sq [N][$];
  logic [8:0] exp_q [$];
  int nfr [N];
  int grant_log [$];
  int mptr, m_g, m_len, m_pop, m_wr, last_g, gap_left, full_mode, cyc, mark, wr0;
  bit m_active, idle_due, exp_trunc, prev_busy, rnd_stall;
  logic [N-1:0] prev_req, force_empty;
  int wr_cnt, eod_cnt, trunc_cnt, pop_cnt;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic bit pending();
    bit q = m_active || gap_left > 0 || idle_due || busy;
    for (int i = 0; i < N; i++) q = q || nfr[i] > 0 || sq[i].size() > 0;
    return q;
  endfunction
  task automatic push_frame(int s, int len);
    for (int b = 0; b < len; b++) sq[s].push_back({1'(b == len - 1), 8'($urandom)});
    nfr[s]++;
  endtask
  task automatic clr();
    wr_cnt = 0; eod_cnt = 0; trunc_cnt = 0; pop_cnt = 0;
  endtask
  task automatic drive();
    logic [8:0] h;
    dst_full = full_mode == 1 ? cyc[0] : full_mode == 2 ? ($urandom_range(9) < 3) : 1'b0;
    cyc++;
    for (int i = 0; i < N; i++) begin
      src_empty[i] = sq[i].size() == 0 || force_empty[i] || (rnd_stall && $urandom_range(9) == 0);
      src_frame_rdy[i] = nfr[i] > 0;
      h = sq[i].size() > 0 ? sq[i][0] : 9'h0;
      src_dout[8*i +: 8] = h[7:0];
      src_eod[i] = h[8];
    end
  endtask
  task automatic start_frame();
    logic [8:0] h;
    exp_q.delete();
    m_len = 0;
    for (int j = 0; j < sq[m_g].size(); j++) begin
      h = sq[m_g][j];
      m_len++;
      if (h[8]) break;
    end
    for (int j = 0; j < m_len && j < ML; j++) begin
      h = sq[m_g][j];
      exp_q.push_back({1'(j == m_len - 1 || j == ML - 1), h[7:0]});
    end
    m_active = 1; m_pop = 0; m_wr = 0; last_g = m_g;
  endtask
  task automatic step();
    bit nt;
    int ri;
    logic [8:0] w;
    @(negedge clk);
    drive();
    #1;
    nt = 0;
    if (gap_left > 0) begin
      chk("gap_busy", busy, 1);
      gap_left--;
      idle_due = gap_left == 0;
    end else if (idle_due) begin
      chk("gap_end", busy, 0);
      idle_due = 0;
    end else if (!prev_busy) begin
      chk("idle_req", busy, |prev_req);
      if (busy) begin
        m_g = pick(prev_req, mptr);
        chk("grant", grant, m_g);
        grant_log.push_back(grant);
        start_frame();
      end
    end
    chk("grant_hold", grant, last_g);
    if (!busy) begin
      chk("idle_rden", src_rden, 0);
      chk("idle_wren", dst_wren, 0);
    end
    chk("rden_onehot", $countones(src_rden) <= 1, 1);
    chk("trunc", trunc_pulse, exp_trunc);
    trunc_cnt += int'(trunc_pulse);
    ri = -1;
    for (int i = 0; i < N; i++) if (src_rden[i]) ri = i;
    if (ri >= 0) begin
      chk("rden_src", ri, m_active ? m_g : -1);
      chk("rden_empty", src_empty[ri], 0);
      if (m_wr < ML) chk("rden_wren", dst_wren, 1);
      pop_cnt++;
      if (sq[ri].size() > 0) begin
        w = sq[ri].pop_front();
        if (w[8]) nfr[ri]--;
      end
    end
    if (dst_wren) begin
      chk("wren_full", dst_full, 0);
      chk("wren_rden", ri >= 0, 1);
      chk("wren_extra", exp_q.size() > 0, 1);
      w = exp_q.size() > 0 ? exp_q.pop_front() : 9'h0;
      chk("dst_byte", {dst_eod, dst_din}, w);
      wr_cnt++;
      eod_cnt += int'(dst_eod);
      m_wr++;
      if (m_wr == ML && m_len > ML) nt = 1;
    end
    if (ri >= 0 && m_active) begin
      m_pop++;
      if (m_pop == m_len) begin
        m_active = 0;
        mptr = m_g;
        chk("frame_left", exp_q.size(), 0);
        gap_left = GAP;
        idle_due = GAP == 0;
      end
    end
    prev_busy = busy;
    prev_req = src_frame_rdy;
    exp_trunc = nt;
  endtask
  task automatic do_reset(int n);
    logic [8:0] w;
    @(negedge clk);
    rst_n = 0;
    src_frame_rdy = '0; src_empty = '1; dst_full = 1; src_eod = '0; src_dout = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
    if (m_active && m_pop > 0)
      while (sq[m_g].size() > 0) begin
        w = sq[m_g].pop_front();
        if (w[8]) begin
          nfr[m_g]--;
          break;
        end
      end
    m_active = 0; exp_q.delete(); mptr = N - 1; last_g = 0; gap_left = 0;
    idle_due = 0; exp_trunc = 0; prev_busy = 0; prev_req = '0;
  endtask
  task automatic drain(string nm, int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (pending() && n < budget);
    chk(nm, pending(), 0);
  endtask
  task automatic wait_wr(string nm, int target, int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_active && m_wr >= target) && n < budget);
    chk(nm, m_active && m_wr >= target, 1);
  endtask
  initial begin
    full_mode = 0; rnd_stall = 0; force_empty = '0; cyc = 0;
    for (int i = 0; i < N; i++) nfr[i] = 0;
    do_reset(2);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_trunc", trunc_pulse, 0);
    // all sources busy, src2 joining only once src1 is being copied
    clr();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      push_frame(0, 20); push_frame(1, 17); push_frame(3, 23);
    end
    begin
      int n = 0;
      while (!(m_active && m_g == 1) && n < 500) begin
        step();
        n++;
      end
    end
    push_frame(2, 19); push_frame(2, 19);
    drain("b_drain", 2000);
    chk("b_cnt", grant_log.size(), 8);
    chk("b_g0", grant_log[0], 0); chk("b_g1", grant_log[1], 1);
    chk("b_g2", grant_log[2], 2); chk("b_g3", grant_log[3], 3);
    chk("b_g4", grant_log[4], 0);
    chk("b_wr", wr_cnt, 2 * (20 + 17 + 19 + 23));
    clr();
    push_frame(0, 64);
    drain("a_drain", 500);
    chk("a_wr", wr_cnt, 64); chk("a_eod", eod_cnt, 1); chk("a_grant", grant, 0);
    clr();
    full_mode = 1;
    push_frame(1, 100);
    drain("c_drain", 1000);
    full_mode = 0;
    chk("c_wr", wr_cnt, 100); chk("c_pop", pop_cnt, 100);
    clr();
    push_frame(3, 1600);
    drain("d_drain", 3000);
    chk("d_wr", wr_cnt, 1518); chk("d_eod", eod_cnt, 1);
    chk("d_trunc", trunc_cnt, 1); chk("d_pop", pop_cnt, 1600);
    mark = grant_log.size();
    push_frame(0, 8); push_frame(1, 8); push_frame(2, 8);
    drain("d2_drain", 500);
    chk("d_next", grant_log[mark], 0);
    clr();
    push_frame(2, 40);
    wait_wr("e_wait", 10, 200);
    force_empty[2] = 1;
    wr0 = wr_cnt;
    repeat (5) step();
    chk("e_stall", wr_cnt - wr0, 0);
    chk("e_busy", busy, 1);
    force_empty = '0;
    drain("e_drain", 500);
    chk("e_wr", wr_cnt, 40);
    clr();
    push_frame(0, 1518); push_frame(1, 1519); push_frame(2, 1);
    drain("l_drain", 8000);
    chk("l_trunc", trunc_cnt, 1); chk("l_wr", wr_cnt, 3037);
    chk("l_eod", eod_cnt, 3); chk("l_pop", pop_cnt, 3038);
    clr();
    push_frame(1, 80);
    wait_wr("f_wait", 30, 300);
    do_reset(1);
    step();
    chk("f_busy", busy, 0); chk("f_rden", src_rden, 0); chk("f_wren", dst_wren, 0);
    for (int i = 0; i < N; i++) push_frame(i, 10);
    mark = grant_log.size();
    drain("f_drain", 1000);
    chk("f_first", grant_log[mark], 0);
    full_mode = 2;
    rnd_stall = 1;
    repeat (5000) begin
      if ($urandom_range(9) == 0) begin
        int s = $urandom_range(N - 1);
        if (nfr[s] < 3) push_frame(s, $urandom_range(79) == 0 ? $urandom_range(1500, 1560) : $urandom_range(1, 64));
      end
      step();
    end
    drain("r_drain", 40000);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Round-robin, frame-atomic scheduler that shares the single PHY transmit FIFO among N_SRC per-port egress FIFOs in the L2 switch.
- Moves exactly one whole frame (bytes plus EOD flag) from the granted source into the PHY TX FIFO, then re-arbitrates.
- Truncates oversize frames and flushes their remainder, so the PHY transmitter only ever sees complete, bounded frames terminated by EOD.

Parameters:
- N_SRC, 4, number of requesting source FIFOs (2..8)
- MAX_LEN, 1518, maximum bytes per frame written downstream (FCS included)
- GAP_CYC, 2, idle cycles after each frame before the next arbitration

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- src_frame_rdy  in  N_SRC  source i holds at least one complete frame (request)
- src_empty  in  N_SRC  source FIFO i empty
- src_dout  in  8*N_SRC  FWFT byte of source i at bits [8i+7:8i]
- src_eod  in  N_SRC  EOD flag aligned with src_dout of source i
- src_rden  out  N_SRC  pop strobe for source i
- dst_full  in  1  PHY TX FIFO full
- dst_din  out  8  byte written downstream
- dst_eod  out  1  EOD flag written with dst_din
- dst_wren  out  1  downstream write strobe
- grant  out  3  index of the current or last granted source
- busy  out  1  high in any state other than S_IDLE
- trunc_pulse  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (rst_n=0 at a clock edge): state S_IDLE, rr_ptr=N_SRC-1, grant=0, byte_cnt=0, gap_cnt=0, trunc_pulse=0. Combinational strobes src_rden, dst_wren and dst_eod are 0 in S_IDLE. Reset mid-frame abandons the frame with no flush.
- States:
  - S_IDLE: if any src_frame_rdy bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_SRC; register it into grant; go to S_COPY. There is no transfer in that same cycle, so grant-to-first-write latency is 1 cycle.
  - S_COPY: xfer = ~src_empty[grant] & ~dst_full.
    - When xfer: src_rden[grant]=1, dst_wren=1, dst_din=src_dout[grant], byte_cnt++.
    - dst_eod = src_eod[grant] | (byte_cnt==MAX_LEN-1).
    - Either condition false: stall with all strobes 0 and state held. Source underrun stalls and is never aborted.
    - xfer with src_eod: rr_ptr<=grant, byte_cnt<=0, go to S_GAP.
    - xfer with byte_cnt==MAX_LEN-1 and no src_eod: trunc_pulse=1 next cycle, byte_cnt<=0, go to S_FLUSH.
  - S_FLUSH: src_rden[grant] = ~src_empty[grant]; no downstream writes. On a popped byte with src_eod: rr_ptr<=grant, go to S_GAP.
  - S_GAP: count gap_cnt 0..GAP_CYC-1, then go to S_IDLE and clear gap_cnt. GAP_CYC=0 goes straight to S_IDLE.
- byte_cnt is 11 bits and saturates logically at MAX_LEN-1; a frame of exactly MAX_LEN bytes with EOD on the last byte is not truncated.
- Request changes during S_COPY, S_FLUSH or S_GAP are ignored. A deasserted src_frame_rdy does not revoke the current grant.
- At most one src_rden bit is high in any cycle.
- A 1-byte frame (src_eod on the first byte) is legal: 1 write, then S_GAP.
- grant holds its value through S_GAP and S_IDLE until the next grant.

Decomposition:
- Shared package tx_sched_pkg: state encoding localparams (S_IDLE, S_COPY, S_FLUSH, S_GAP), the MAX_LEN default, and the byte-counter width.
- One sub-module, rr_pick: a combinational round-robin selector taking req[N_SRC] and ptr, returning idx and valid. It is reused by later RX-side arbiters.

Test Plan:
- Src0 only, 64-byte frame, dst never full: 64 dst_wren, dst_eod only on byte 64, grant=0, then 2 idle cycles, then idle.
- All 4 sources request continuously: grant sequence 0,1,2,3,0 with every frame intact. A src2 request arriving during src1's copy waits its turn.
- dst_full toggled every other cycle during a 100-byte frame: exactly 100 writes, no src_rden while dst_full=1, byte order preserved.
- 1600-byte frame from src3: 1518 writes, EOD on write 1518, one trunc_pulse, 82 flush pops with no writes, next grant goes to src0.
- Source empty for 5 cycles mid-frame: state held in S_COPY with no strobes, transfer resumes and the frame completes unaltered.
- Reset asserted at byte 30 of a frame: next cycle all strobes 0, busy=0, and the first grant after reset goes to src0 when all sources request.
